freq_lock_controller: RTL and testbench

Sequences and supervises the sync-frequency counter in the QCM master controller. It clears and restarts the counter and discards the first, partial measurement window. It qualifies incoming frequency words (hundreds of Hz) with an agreement/hysteresis filter, so the ±1-LSB jitter between adjacent measurements never reaches downstream logic. It also declares lock or loss-of-signal. The block sits between the counter's frequency output and every consumer of the measured frequency.

---
 rtl/freq_lock_controller.sv | 176 +++++++++++++++++
 tb/tb_freq_lock_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_lock_controller.sv
// Supervises the sync-frequency counter: restart sequencing, jitter-rejecting qualification, lock/loss-of-signal.
// All outputs registered; f_out/f_upd/locked follow the qualifying f_valid by one clock, no input backpressure.
module freq_lock_controller #(
   parameter int W       = 14,
   parameter int TOL     = 1,
   parameter int N_AGREE = 3,
   parameter int TIMEOUT = 8192,
   parameter int TW      = 16
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_enable,
   input  logic [W-1:0] i_f_in,
   input  logic         i_f_valid,
   output logic         o_counter_clr,
   output logic [W-1:0] o_f_out,
   output logic         o_f_upd,
   output logic         o_locked,
   output logic         o_lost
);
   localparam int              AW    = $clog2(N_AGREE + 1);
   localparam int              WP    = W + 1;
   localparam logic [AW-1:0]   N_CNT = AW'(N_AGREE);
   localparam logic [AW-1:0]   ONE   = AW'(1);
   localparam logic [TW-1:0]   T_CNT = TW'(TIMEOUT);
   localparam logic signed [W:0] TOL_V = $signed(WP'(TOL));

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_DISCARD, S_ACQUIRE, S_LOCKED, S_LOST
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [W-1:0]  r_ref, w_ref_nxt;
   logic [W-1:0]  r_cand, w_cand_nxt;
   logic [W-1:0]  r_f_out, w_f_out_nxt;
   logic [AW-1:0] r_agree, w_agree_nxt;
   logic [AW-1:0] r_dev, w_dev_nxt;
   logic [TW-1:0] r_tmo, w_tmo_nxt, w_tmo_inc;
   logic          r_clr_cnt, w_clr_cnt_nxt;
   logic          r_f_upd, w_f_upd_nxt;
   logic          r_locked, w_locked_nxt;
   logic          r_lost, w_lost_nxt;
   logic          r_counter_clr;
   logic          w_timeout;

   // Difference taken on W+1 signed bits so words at opposite ends of the range never wrap into agreement.
   function automatic logic near(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      if (d[W]) d = -d;
      return (d <= TOL_V);
   endfunction

   assign w_timeout = (r_tmo == T_CNT);
   assign w_tmo_inc = w_timeout ? r_tmo : r_tmo + TW'(1);

   always_comb begin
      w_state_nxt   = r_state;
      w_ref_nxt     = r_ref;
      w_cand_nxt    = r_cand;
      w_agree_nxt   = r_agree;
      w_dev_nxt     = r_dev;
      w_tmo_nxt     = r_tmo;
      w_clr_cnt_nxt = 1'b0;
      w_f_out_nxt   = r_f_out;
      w_f_upd_nxt   = 1'b0;
      w_locked_nxt  = r_locked;
      w_lost_nxt    = r_lost;
      if (!i_enable) begin
         w_state_nxt  = S_IDLE;
         w_agree_nxt  = '0;
         w_dev_nxt    = '0;
         w_tmo_nxt    = '0;
         w_locked_nxt = 1'b0;
         w_lost_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: w_state_nxt = S_CLEAR;
            S_CLEAR: begin
               if (r_clr_cnt) begin
                  w_state_nxt = S_DISCARD;
                  w_tmo_nxt   = '0;
               end else begin
                  w_clr_cnt_nxt = 1'b1;
               end
            end
            S_DISCARD, S_ACQUIRE, S_LOCKED: begin
               if (i_f_valid) begin
                  w_tmo_nxt = '0;
                  if (r_state == S_DISCARD) begin
                     w_state_nxt = S_ACQUIRE;
                     w_agree_nxt = '0;
                  end else if (r_state == S_ACQUIRE) begin
                     if (r_agree == '0 || !near(i_f_in, r_ref)) begin
                        w_ref_nxt   = i_f_in;
                        w_agree_nxt = ONE;
                     end else begin
                        w_agree_nxt = r_agree + ONE;
                     end
                     if (w_agree_nxt == N_CNT) begin
                        w_f_out_nxt  = w_ref_nxt;
                        w_f_upd_nxt  = (w_ref_nxt != r_f_out);
                        w_locked_nxt = 1'b1;
                        w_lost_nxt   = 1'b0;
                        w_agree_nxt  = '0;
                        w_dev_nxt    = '0;
                        w_state_nxt  = S_LOCKED;
                     end
                  end else if (near(i_f_in, r_f_out)) begin
                     w_dev_nxt = '0;
                  end else begin
                     if (r_dev == '0 || !near(i_f_in, r_cand)) begin
                        w_cand_nxt = i_f_in;
                        w_dev_nxt  = ONE;
                     end else begin
                        w_dev_nxt = r_dev + ONE;
                     end
                     if (w_dev_nxt == N_CNT) begin
                        w_f_out_nxt = w_cand_nxt;
                        w_f_upd_nxt = 1'b1;
                        w_dev_nxt   = '0;
                     end
                  end
               end else if (w_timeout) begin
                  w_state_nxt  = S_LOST;
                  w_locked_nxt = 1'b0;
                  w_lost_nxt   = 1'b1;
                  w_tmo_nxt    = '0;
                  w_agree_nxt  = '0;
                  w_dev_nxt    = '0;
               end else begin
                  w_tmo_nxt = w_tmo_inc;
               end
            end
            S_LOST: if (i_f_valid) w_state_nxt = S_CLEAR;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         r_ref         <= '0;
         r_cand        <= '0;
         r_f_out       <= '0;
         r_agree       <= '0;
         r_dev         <= '0;
         r_tmo         <= '0;
         r_clr_cnt     <= 1'b0;
         r_f_upd       <= 1'b0;
         r_locked      <= 1'b0;
         r_lost        <= 1'b0;
         r_counter_clr <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_ref         <= w_ref_nxt;
         r_cand        <= w_cand_nxt;
         r_f_out       <= w_f_out_nxt;
         r_agree       <= w_agree_nxt;
         r_dev         <= w_dev_nxt;
         r_tmo         <= w_tmo_nxt;
         r_clr_cnt     <= w_clr_cnt_nxt;
         r_f_upd       <= w_f_upd_nxt;
         r_locked      <= w_locked_nxt;
         r_lost        <= w_lost_nxt;
         r_counter_clr <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CLEAR);
      end
   end

   assign o_counter_clr = r_counter_clr;
   assign o_f_out       = r_f_out;
   assign o_f_upd       = r_f_upd;
   assign o_locked      = r_locked;
   assign o_lost        = r_lost;
endmodule

// File: tb/tb_freq_lock_controller.sv
// Bench for freq_lock_controller: spec vector table, hand-built corner sequences and a randomized run,
// with every cycle also compared against a queue/timestamp reference model.
module tb_freq_lock_controller;
   localparam int W       = 14;
   localparam int TOL     = 1;
   localparam int N_AGREE = 3;
   localparam int TIMEOUT = 8192;
   localparam int TW      = 16;

   logic         clk = 1'b0;
   logic         reset_n, enable, f_valid;
   logic [W-1:0] f_in;
   logic         counter_clr, f_upd, locked, lost;
   logic [W-1:0] f_out;

   freq_lock_controller #(.W(W), .TOL(TOL), .N_AGREE(N_AGREE), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_f_in(f_in), .i_f_valid(f_valid),
      .o_counter_clr(counter_clr), .o_f_out(f_out), .o_f_upd(f_upd), .o_locked(locked), .o_lost(lost)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: modes, a queue holding the current agreeing run, and edge timestamps for the timeout.
   localparam int MI = 0, MC = 1, MD = 2, MA = 3, ML = 4, MS = 5;
   int m_mode = MI;
   int m_clear_left = 0;
   int m_edge = 0;
   int m_last_evt = 0;
   int run_q[$];
   int cand_q[$];
   int m_fout = 0;
   bit m_upd = 0, m_locked = 0, m_lost = 0, m_clr = 1;

   function automatic bit near(input int a, input int b);
      return (a - b <= TOL) && (b - a <= TOL);
   endfunction

   task automatic model_step();
      int s;
      s = int'(f_in);
      m_edge++;
      m_upd = 0;
      if (!reset_n) begin
         m_mode = MI; m_fout = 0; m_locked = 0; m_lost = 0;
         run_q.delete(); cand_q.delete();
      end else if (!enable) begin
         m_mode = MI; m_locked = 0; m_lost = 0;
         run_q.delete(); cand_q.delete();
      end else begin
         case (m_mode)
            MI: begin m_mode = MC; m_clear_left = 2; end
            MC: begin
               m_clear_left--;
               if (m_clear_left == 0) begin m_mode = MD; m_last_evt = m_edge; end
            end
            MS: if (f_valid) begin m_mode = MC; m_clear_left = 2; end
            default: begin
               if (f_valid) begin
                  m_last_evt = m_edge;
                  if (m_mode == MD) begin
                     m_mode = MA; run_q.delete();
                  end else if (m_mode == MA) begin
                     if (run_q.size() > 0 && near(s, run_q[0])) run_q.push_back(s);
                     else begin run_q.delete(); run_q.push_back(s); end
                     if (run_q.size() == N_AGREE) begin
                        m_upd = (run_q[0] != m_fout);
                        m_fout = run_q[0];
                        m_locked = 1; m_lost = 0; m_mode = ML;
                        run_q.delete(); cand_q.delete();
                     end
                  end else if (near(s, m_fout)) begin
                     cand_q.delete();
                  end else begin
                     if (cand_q.size() > 0 && near(s, cand_q[0])) cand_q.push_back(s);
                     else begin cand_q.delete(); cand_q.push_back(s); end
                     if (cand_q.size() == N_AGREE) begin
                        m_fout = cand_q[0]; m_upd = 1; cand_q.delete();
                     end
                  end
               end else if (m_edge - m_last_evt > TIMEOUT) begin
                  m_mode = MS; m_locked = 0; m_lost = 1;
                  run_q.delete(); cand_q.delete();
               end
            end
         endcase
      end
      m_clr = (m_mode == MI) || (m_mode == MC);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_model();
      logic [W+3:0] act, exp;
      act = {counter_clr, f_upd, locked, lost, f_out};
      exp = {m_clr, m_upd, m_locked, m_lost, W'(m_fout)};
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL model @%0t: clr/upd/locked/lost/f_out got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                    $time, counter_clr, f_upd, locked, lost, f_out, m_clr, m_upd, m_locked, m_lost, m_fout);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic send(input int gap, input int v);
      f_valid = 1'b0;
      repeat (gap) tick();
      f_valid = 1'b1;
      f_in = W'(v);
      tick();
      f_valid = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_clr"}, int'(counter_clr), 1);
      check({tag, "_fout"}, int'(f_out), 0);
      check({tag, "_upd"}, int'(f_upd), 0);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_lost"}, int'(lost), 0);
   endtask

   typedef struct {
      int gap;
      int fin;
      int e_locked;
      int e_upd;
      int e_fout;
   } vec_t;
   vec_t vecs[16];

   int bases[4] = '{0, 16383, 1, 3075};
   int base, r, v, gap;

   initial begin
      vecs[0]  = '{1400, 9999, 0, 0, 0};
      vecs[1]  = '{1400, 3075, 0, 0, 0};
      vecs[2]  = '{1400, 3076, 0, 0, 0};
      vecs[3]  = '{1400, 3075, 1, 1, 3075};
      vecs[4]  = '{1400, 3076, 1, 0, 3075};
      vecs[5]  = '{1400, 3074, 1, 0, 3075};
      vecs[6]  = '{0,    1300, 1, 0, 3075};
      vecs[7]  = '{0,    1301, 1, 0, 3075};
      vecs[8]  = '{0,    1300, 1, 1, 1300};
      vecs[9]  = '{20,   3075, 1, 0, 1300};
      vecs[10] = '{20,   3076, 1, 0, 1300};
      vecs[11] = '{20,   3075, 1, 1, 3075};
      vecs[12] = '{30,   2000, 1, 0, 3075};
      vecs[13] = '{30,   3075, 1, 0, 3075};
      vecs[14] = '{30,   1300, 1, 0, 3075};
      vecs[15] = '{30,   3075, 1, 0, 3075};

      reset_n = 1'b0; enable = 1'b0; f_valid = 1'b0; f_in = '0;
      repeat (3) tick();
      check_reset_vals("reset");
      reset_n = 1'b1;
      tick();
      check("idle_clr", int'(counter_clr), 1);

      enable = 1'b1;
      tick(); check("clear1_clr", int'(counter_clr), 1);
      tick(); check("clear2_clr", int'(counter_clr), 1);
      tick(); check("discard_clr", int'(counter_clr), 0);

      for (int i = 0; i < 16; i++) begin
         send(vecs[i].gap, vecs[i].fin);
         check($sformatf("vec%0d_locked", i), int'(locked), vecs[i].e_locked);
         check($sformatf("vec%0d_upd", i), int'(f_upd), vecs[i].e_upd);
         check($sformatf("vec%0d_fout", i), int'(f_out), vecs[i].e_fout);
      end

      // Loss of signal and reacquisition.
      repeat (TIMEOUT) tick();
      check("lost_early", int'(lost), 0);
      check("locked_early", int'(locked), 1);
      tick();
      check("lost_set", int'(lost), 1);
      check("lost_unlocked", int'(locked), 0);
      check("lost_fout_held", int'(f_out), 3075);
      send(0, 5000);
      check("lost_to_clear", int'(counter_clr), 1);
      tick(); check("relock_clear2", int'(counter_clr), 1);
      tick(); check("relock_discard", int'(counter_clr), 0);
      send(5, 4000);
      repeat (3) send(5, 1300);
      check("relock_locked", int'(locked), 1);
      check("relock_lost", int'(lost), 0);
      check("relock_fout", int'(f_out), 1300);

      // f_valid landing on the terminal timeout count is processed, not a timeout.
      send(TIMEOUT, 2000);
      check("tmo_edge_lost", int'(lost), 0);
      check("tmo_edge_locked", int'(locked), 1);
      send(0, 2000);
      send(0, 2000);
      check("tmo_edge_fout", int'(f_out), 2000);
      check("tmo_edge_upd", int'(f_upd), 1);

      enable = 1'b0;
      tick();
      check("dis_clr", int'(counter_clr), 1);
      check("dis_locked", int'(locked), 0);
      check("dis_fout", int'(f_out), 2000);
      enable = 1'b1;
      repeat (3) tick();
      send(3, 9000);
      send(3, 700);
      send(3, 700);
      enable = 1'b0;
      tick();
      check("acq_dis_clr", int'(counter_clr), 1);
      check("acq_dis_locked", int'(locked), 0);
      check("acq_dis_fout", int'(f_out), 2000);
      enable = 1'b1;
      repeat (3) tick();
      send(2, 9000);
      repeat (3) send(2, 2500);
      check("reacq_locked", int'(locked), 1);
      check("reacq_fout", int'(f_out), 2500);

      // Reset while locked, coincident with a sample.
      reset_n = 1'b0; f_valid = 1'b1; f_in = W'(100);
      tick();
      f_valid = 1'b0;
      check_reset_vals("midreset");
      reset_n = 1'b1;

      // Range ends must not agree through wraparound; locking onto the old value raises no f_upd.
      repeat (3) tick();
      send(2, 5555);
      send(2, 16383); send(2, 0); send(2, 16383); send(2, 0); send(2, 0);
      check("wrap_nolock", int'(locked), 0);
      send(2, 0);
      check("wrap_lock", int'(locked), 1);
      check("wrap_noupd", int'(f_upd), 0);

      base = 3075;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 4) base = bases[r];
         else if (r < 8) base = int'($urandom_range(0, 16383));
         if (r >= 8 && r < 14) v = int'($urandom_range(0, 16383));
         else v = base + int'($urandom_range(0, 4)) - 2;
         if (v < 0) v = 0;
         if (v > 16383) v = 16383;
         if (r >= 97) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            enable = 1'b1;
         end
         if (i == 150) gap = TIMEOUT + 3;
         else if (i == 250) gap = TIMEOUT;
         else gap = int'($urandom_range(0, 20));
         send(gap, v);
      end
      repeat (5) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
